// File: rtl/sgpio_rx_deser_if.sv
// SGPIO receive bus: serial pins from the baseboard CPLD plus the deserialized
// drive-activity results. The deserializer uses the slave modport.
interface sgpio_rx_deser_if #(
    parameter int NBITS = 36
);
    logic             SGPIO_CK;
    logic             SGPIO_LD;
    logic             SGPIO_DATA;
    logic [NBITS-1:0] ACT_LED;
    logic             FRAME_VALID;
    logic             FRAME_ERR;
    logic             LINK_OK;

    modport master (
        output SGPIO_CK, SGPIO_LD, SGPIO_DATA,
        input  ACT_LED, FRAME_VALID, FRAME_ERR, LINK_OK
    );

    modport slave (
        input  SGPIO_CK, SGPIO_LD, SGPIO_DATA,
        output ACT_LED, FRAME_VALID, FRAME_ERR, LINK_OK
    );
endinterface

// File: rtl/sgpio_rx_deser.sv
// SGPIO frame deserializer: synchronizes the serial pins, collects NBITS-bit
// frames, optionally qualifies them by repetition and watches link activity.
module sgpio_rx_deser #(
    parameter int NBITS   = 36,
    parameter int TIMEOUT = 50000,
    parameter int FILTER  = 1
) (
    input logic              SYSCLK,
    input logic              RESET_N,
    sgpio_rx_deser_if.slave  sgpio
);
    localparam int CW = $clog2(NBITS + 1);
    localparam int IW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, OVERRUN = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             ck_meta_q, ck_sync_q, ck_prev_q;
    logic             ld_meta_q, ld_sync_q;
    logic             dat_meta_q, dat_sync_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic             long_err_q, long_err_d;
    logic             done_q, err_q;
    logic [NBITS-1:0] cmp_q, act_q;
    logic             cmp_vld_q, fv_q, link_q;
    logic [IW-1:0]    idle_q;
    logic             sample, timeout;
    logic             complete, err_short, err_long;

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ck_meta_q  <= 1'b0;
            ck_sync_q  <= 1'b0;
            ck_prev_q  <= 1'b0;
            ld_meta_q  <= 1'b0;
            ld_sync_q  <= 1'b0;
            dat_meta_q <= 1'b0;
            dat_sync_q <= 1'b0;
        end else begin
            ck_meta_q  <= sgpio.SGPIO_CK;
            ck_sync_q  <= ck_meta_q;
            ck_prev_q  <= ck_sync_q;
            ld_meta_q  <= sgpio.SGPIO_LD;
            ld_sync_q  <= ld_meta_q;
            dat_meta_q <= sgpio.SGPIO_DATA;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign sample  = ck_sync_q & ~ck_prev_q;
    assign timeout = (idle_q == IW'(TIMEOUT));

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            idle_q <= '0;
            link_q <= 1'b0;
        end else begin
            if (sample)        idle_q <= '0;
            else if (!timeout) idle_q <= idle_q + 1'b1;
            if (sample)        link_q <= 1'b1;
            else if (timeout)  link_q <= 1'b0;
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sample) begin
            if (ld_sync_q)                                           state_d = SHIFT;
            else if (state_q == SHIFT && cnt_q == CW'(NBITS - 1))    state_d = OVERRUN;
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        complete  = sample && !ld_sync_q && state_q == SHIFT && cnt_q == CW'(NBITS - 1);
        err_short = sample && ld_sync_q && state_q == SHIFT;
        err_long  = sample && !ld_sync_q && state_q == OVERRUN && !long_err_q;
    end

    // Bit collection: LD always restarts at bit 0, whatever state we were in.
    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        long_err_d = long_err_q;
        if (sample && ld_sync_q) begin
            shift_d[0] = dat_sync_q;
            cnt_d      = CW'(1);
            long_err_d = 1'b0;
        end else if (sample && state_q == SHIFT) begin
            for (int i = 0; i < NBITS; i++) begin
                if (cnt_q == CW'(i)) shift_d[i] = dat_sync_q;
            end
            cnt_d = cnt_q + CW'(1);
        end
        if (err_long) long_err_d = 1'b1;
    end

    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            long_err_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            long_err_q <= long_err_d;
            done_q     <= complete;
            err_q      <= err_short | err_long;
        end
    end

    // Qualification stage: one cycle after completion, before the next sample can land.
    always_ff @(posedge SYSCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            act_q     <= '0;
            cmp_q     <= '0;
            cmp_vld_q <= 1'b0;
            fv_q      <= 1'b0;
        end else begin
            fv_q <= 1'b0;
            if (timeout) begin
                act_q     <= '0;
                cmp_vld_q <= 1'b0;
            end else if (done_q) begin
                if (FILTER == 0 || (cmp_vld_q && shift_q == cmp_q)) begin
                    act_q <= shift_q;
                    fv_q  <= 1'b1;
                end
                cmp_q     <= shift_q;
                cmp_vld_q <= 1'b1;
            end
        end
    end

    assign sgpio.ACT_LED     = act_q;
    assign sgpio.FRAME_VALID = fv_q;
    assign sgpio.FRAME_ERR   = err_q;
    assign sgpio.LINK_OK     = link_q;
endmodule

// File: tb/tb_sgpio_rx_deser.sv
// Directed and randomized bench for sgpio_rx_deser with a frame-level
// reference model of repetition qualification, errors and link timeout.
module tb_sgpio_rx_deser;
    localparam int NB  = 36;
    localparam int TO  = 300;
    localparam int FLT = 1;

    logic SYSCLK = 1'b0;
    logic RESET_N;
    always #5 SYSCLK = ~SYSCLK;

    sgpio_rx_deser_if #(.NBITS(NB)) bus ();

    sgpio_rx_deser #(.NBITS(NB), .TIMEOUT(TO), .FILTER(FLT)) dut (
        .SYSCLK (SYSCLK),
        .RESET_N(RESET_N),
        .sgpio  (bus)
    );

    int checks = 0, errors = 0;
    int fv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int exp_fv = 0, exp_fe = 0;
    logic [NB-1:0] m_prev, m_act;
    bit            m_prev_vld;

    always @(negedge SYSCLK) begin
        if (bus.FRAME_VALID === 1'b1) fv_cnt++;
        if (bus.FRAME_ERR === 1'b1) fe_cnt++;
        if (bus.FRAME_VALID === 1'b1 && bus.FRAME_ERR === 1'b1) both_cnt++;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_frame(input logic [NB-1:0] f);
        if (FLT == 0 || (m_prev_vld && f == m_prev)) begin
            m_act = f;
            exp_fv++;
        end
        m_prev     = f;
        m_prev_vld = 1'b1;
    endfunction

    function automatic void model_clear();
        m_act      = '0;
        m_prev_vld = 1'b0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic ld, input logic d, input int j);
        repeat (4) @(posedge SYSCLK);
        #(j);
        bus.SGPIO_CK   = 1'b0;
        bus.SGPIO_LD   = ld;
        bus.SGPIO_DATA = d;
        repeat (4) @(posedge SYSCLK);
        #(j);
        bus.SGPIO_CK = 1'b1;
    endtask

    task automatic send_bits(input logic [63:0] f, input int n, input bit fixed_phase);
        for (int i = 0; i < n; i++)
            send_bit(i == 0, f[i], fixed_phase ? 1 : int'($urandom_range(1, 9)));
    endtask

    task automatic settle();
        repeat (8) @(posedge SYSCLK);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_act"}, 64'(bus.ACT_LED), 64'(m_act));
        check({tag, "_fv"}, 64'(fv_cnt), 64'(exp_fv));
        check({tag, "_fe"}, 64'(fe_cnt), 64'(exp_fe));
    endtask

    // Sends one well-formed frame; with lat set, pins the update to the 4th SYSCLK edge.
    task automatic send_frame(input string tag, input logic [NB-1:0] f, input bit lat);
        logic [NB-1:0] old;
        old = m_act;
        send_bits(64'(f), NB, lat);
        model_frame(f);
        if (lat) begin
            repeat (3) @(posedge SYSCLK);
            #1;
            check({tag, "_lat3_fv"}, 64'(bus.FRAME_VALID), 64'd0);
            check({tag, "_lat3_act"}, 64'(bus.ACT_LED), 64'(old));
            @(posedge SYSCLK);
            #1;
            check({tag, "_lat4_fv"}, 64'(bus.FRAME_VALID), 64'd1);
            check({tag, "_lat4_act"}, 64'(bus.ACT_LED), 64'(m_act));
        end
        settle();
        check_state(tag);
    endtask

    initial begin
        logic [63:0]   r;
        logic [NB-1:0] f;
        bus.SGPIO_CK   = 1'b0;
        bus.SGPIO_LD   = 1'b0;
        bus.SGPIO_DATA = 1'b0;
        RESET_N        = 1'b0;
        m_prev         = '0;
        model_clear();
        repeat (3) @(posedge SYSCLK);
        #1;
        check("rst_act", 64'(bus.ACT_LED), 64'd0);
        check("rst_fv", 64'(bus.FRAME_VALID), 64'd0);
        check("rst_fe", 64'(bus.FRAME_ERR), 64'd0);
        check("rst_link", 64'(bus.LINK_OK), 64'd0);
        @(negedge SYSCLK);
        RESET_N = 1'b1;

        // Repetition qualification and exact latency
        send_frame("q1a", 36'hB_0000_0005, 1'b0);
        check("q1_link", 64'(bus.LINK_OK), 64'd1);
        send_frame("q1b", 36'hB_0000_0005, 1'b1);
        send_frame("q2a", 36'hB_1108_0005, 1'b0);
        send_frame("q2b", 36'hB_1108_0006, 1'b0);
        send_frame("q2c", 36'hB_1108_0006, 1'b0);

        // Short frame, then a long frame whose first NBITS bits qualify
        r = {$urandom, $urandom};
        send_bits(r, 20, 1'b0);
        exp_fe++;
        send_frame("short", 36'h3_CAFE_0001, 1'b0);
        r = {$urandom, $urandom};
        r[NB-1:0] = 36'h3_CAFE_0001;
        send_bits(r, NB + 2, 1'b0);
        model_frame(36'h3_CAFE_0001);
        exp_fe++;
        settle();
        check_state("long");

        // Link timeout and recovery
        send_frame("ones_a", 36'hF_FFFF_FFFF, 1'b0);
        send_frame("ones_b", 36'hF_FFFF_FFFF, 1'b0);
        repeat (TO + 20) @(posedge SYSCLK);
        #1;
        model_clear();
        check("to_link", 64'(bus.LINK_OK), 64'd0);
        check_state("to");
        send_frame("to_ones", 36'hF_FFFF_FFFF, 1'b0);
        check("to_relink", 64'(bus.LINK_OK), 64'd1);
        send_frame("to_one_a", 36'h0_0000_0001, 1'b0);
        send_frame("to_one_b", 36'h0_0000_0001, 1'b0);

        // Asynchronous reset in the middle of a frame
        send_bits(64'h5_A5A5_1234, 17, 1'b0);
        @(negedge SYSCLK);
        #2;
        RESET_N      = 1'b0;
        bus.SGPIO_CK = 1'b0;
        #1;
        check("mrst_act", 64'(bus.ACT_LED), 64'd0);
        check("mrst_link", 64'(bus.LINK_OK), 64'd0);
        check("mrst_fv", 64'(bus.FRAME_VALID), 64'd0);
        check("mrst_fe", 64'(bus.FRAME_ERR), 64'd0);
        repeat (2) @(negedge SYSCLK);
        RESET_N = 1'b1;
        model_clear();
        send_frame("mrst_a", 36'h5_A5A5_1234, 1'b0);
        send_frame("mrst_b", 36'h5_A5A5_1234, 1'b0);

        // Random frames in pairs with random pin phase
        for (int p = 0; p < 80; p++) begin
            r = {$urandom, $urandom};
            f = r[NB-1:0];
            send_frame("rnd_a", f, 1'b0);
            send_frame("rnd_b", f, 1'b0);
        end

        check("never_both", 64'(both_cnt), 64'd0);
        check("final_fe", 64'(fe_cnt), 64'(exp_fe));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
